// File: rtl/serial_tx.sv
// Serial transmitter fed by the 1-byte shared register: completes the rd handshake,
// captures the byte and sends it as an 8N1-style frame (1 or 2 stop bits) on tx.
module serial_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       has_data,
    input  logic [7:0] rd_data,
    output logic       rd,
    output logic       tx,
    output logic       busy
);

    // state   | meaning
    // IDLE    | line idle high, waiting for has_data
    // ACK     | rd high for exactly one clock
    // RELEASE | wait for the upstream register to drop has_data
    // START   | start bit (tx=0)
    // DATA    | 8 data bits, LSB first
    // STOP    | stop bit(s), tx=1
    typedef enum logic [2:0] {
        IDLE,
        ACK,
        RELEASE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = (STOP_BITS == 2);

    state_t      state, state_nxt;
    logic [7:0]  shift, shift_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic        stop_cnt, stop_cnt_nxt;
    logic        rd_nxt, tx_nxt, busy_nxt;
    logic        bit_done;

    assign bit_done = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            shift    <= '0;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            rd       <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            shift    <= shift_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            stop_cnt <= stop_cnt_nxt;
            rd       <= rd_nxt;
            tx       <= tx_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift;
        cnt_nxt      = cnt;
        bit_idx_nxt  = bit_idx;
        stop_cnt_nxt = stop_cnt;
        rd_nxt       = rd;
        tx_nxt       = tx;
        busy_nxt     = busy;

        unique case (state)
            IDLE: begin
                tx_nxt   = 1'b1;
                rd_nxt   = 1'b0;
                busy_nxt = 1'b0;
                if (has_data) begin
                    shift_nxt = rd_data;
                    rd_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                rd_nxt    = 1'b0;
                state_nxt = RELEASE;
            end
            RELEASE: begin
                // a stale has_data must not start a second read of the same byte
                if (!has_data) begin
                    tx_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    tx_nxt      = shift[0];
                    state_nxt   = DATA;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        tx_nxt       = 1'b1;
                        stop_cnt_nxt = 1'b0;
                        state_nxt    = STOP;
                    end else begin
                        shift_nxt   = {1'b0, shift[7:1]};
                        tx_nxt      = shift[1];
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_nxt = '0;
                    if (stop_cnt == STOP_LAST) begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
